// File: rtl/uart_tx.sv
// 8N1-style UART transmitter: start bit, DATA_BITS data bits LSB first, STOP_BITS stop bits, N clk per bit.
// Line falls one cycle after accept; tx_ready is high only while idle, so a held tx_valid waits for the frame to end.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          baud_rate_control,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 data_line,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e                 state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [15:0]            n_q;
    logic [15:0]            baud_cnt_q;
    logic [3:0]             bit_cnt_q;
    logic                   line_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;

    logic [15:0]            n_d;
    logic [15:0]            baud_cnt_d;
    logic                   baud_last;
    logic                   baud_pre_last;

    // Bit periods below 2 cycles cannot be represented by the counter scheme, so clamp.
    assign n_d           = (baud_rate_control < 16'd2) ? 16'd2 : baud_rate_control;
    assign baud_cnt_d    = baud_cnt_q + 16'd1;
    assign baud_last     = (baud_cnt_q == n_q - 16'd1);
    assign baud_pre_last = (baud_cnt_q == n_q - 16'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            n_q        <= 16'd2;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 4'd0;
            line_q     <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid && ready_q) begin
                        shift_q    <= tx_data;
                        n_q        <= n_d;
                        baud_cnt_q <= 16'd0;
                        bit_cnt_q  <= 4'd0;
                        line_q     <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt_q <= 16'd0;
                        line_q     <= shift_q[0];
                        state_q    <= DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_d;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt_q <= 16'd0;
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= 4'd0;
                            line_q    <= 1'b1;
                            state_q   <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            shift_q   <= shift_q >> 1;
                            line_q    <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_d;
                    end
                end
                STOP: begin
                    // Raise done one edge early so it is visible during the final stop cycle.
                    if (bit_cnt_q == LAST_STOP && baud_pre_last) begin
                        done_q <= 1'b1;
                    end
                    if (baud_last) begin
                        baud_cnt_q <= 16'd0;
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q <= 4'd0;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    line_q  <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_line = line_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule
